// File: rtl/regfile_pkg.sv
// Shared types for the context-switching register file.
// Holds the nesting-level and register-address types plus REG_ZERO.
package regfile_pkg;

    localparam int PKG_CTX_DEPTH = 4;
    localparam int PKG_LVL_W     = $clog2(PKG_CTX_DEPTH + 1);

    typedef logic [PKG_LVL_W-1:0] ctx_lvl_t;
    typedef logic [4:0]           reg_addr_t;

    localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/regfile_ctx_stack.sv
// Context stack: saved copies of masked registers, depth counter, error pulse.
// Ports: push_i/pop_i ops, gated pipeline write (we_i, wr_*), live_i snapshot source;
// outputs depth/full/empty/err, live_we_o routing, restore_o/restore_en_o for pops.
module regfile_ctx_stack
    import regfile_pkg::*;
#(
    parameter int          NUM_REGS  = 32,
    parameter int          DATA_W    = 32,
    parameter logic [31:0] SAVE_MASK = 32'h0000_0006,
    parameter int          CTX_DEPTH = 4,
    parameter int          LVL_W     = $clog2(CTX_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic              we_i,
    input  reg_addr_t         wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [LVL_W-1:0]  wr_ctx_i,
    input  logic [DATA_W-1:0] live_i [NUM_REGS],
    output logic [LVL_W-1:0]  depth_o,
    output logic              full_o,
    output logic              empty_o,
    output logic              err_o,
    output logic              live_we_o,
    output logic              restore_en_o,
    output logic [DATA_W-1:0] restore_o [NUM_REGS]
);

    logic [LVL_W-1:0] depth_q, depth_d, depth_m1;
    logic             err_q, err_d;
    logic             full, empty, bad_op;
    logic             push_ok, pop_ok;
    logic             ctx_eq, ctx_lt, masked;
    logic             stk_we, drop;

    assign full     = depth_q == LVL_W'(CTX_DEPTH);
    assign empty    = depth_q == '0;
    assign depth_m1 = depth_q - 1'b1;

    assign bad_op  = (push_i && pop_i) || (push_i && full) || (pop_i && empty);
    assign push_ok = push_i && !pop_i && !full;
    assign pop_ok  = pop_i && !push_i && !empty;

    // Writes issued at an outer level land in that level's saved copy
    // when the register is part of the saved subset.
    assign ctx_eq    = wr_ctx_i == depth_q;
    assign ctx_lt    = wr_ctx_i < depth_q;
    assign masked    = SAVE_MASK[wr_addr_i];
    assign live_we_o = we_i && (ctx_eq || (ctx_lt && !masked));
    assign stk_we    = we_i && ctx_lt && masked;
    assign drop      = we_i && !ctx_eq && !ctx_lt;

    always_comb begin
        depth_d = depth_q;
        if (push_ok) begin
            depth_d = depth_q + 1'b1;
        end else if (pop_ok) begin
            depth_d = depth_m1;
        end
        err_d = bad_op || drop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
        if (r != 0 && SAVE_MASK[r]) begin : g_sv
            logic [DATA_W-1:0] slot_q [CTX_DEPTH];
            logic [DATA_W-1:0] snap, rv;
            logic              hit_live, hit_stk;

            assign hit_live = live_we_o && wr_addr_i == 5'(r);
            assign hit_stk  = stk_we && wr_addr_i == 5'(r);
            // Snapshot sees a same-cycle live write.
            assign snap     = hit_live ? wr_data_i : live_i[r];

            // Push targets slot D, shadow writes target slots below D.
            always_ff @(posedge clk) begin
                for (int s = 0; s < CTX_DEPTH; s++) begin
                    if (rst) begin
                        slot_q[s] <= '0;
                    end else if (push_ok && depth_q == LVL_W'(s)) begin
                        slot_q[s] <= snap;
                    end else if (hit_stk && wr_ctx_i == LVL_W'(s)) begin
                        slot_q[s] <= wr_data_i;
                    end
                end
            end

            // A shadow write to the slot being popped wins over its old value.
            always_comb begin
                rv = '0;
                for (int s = 0; s < CTX_DEPTH; s++) begin
                    if (depth_m1 == LVL_W'(s)) begin
                        rv = slot_q[s];
                    end
                end
                if (hit_stk && wr_ctx_i == depth_m1) begin
                    rv = wr_data_i;
                end
            end

            assign restore_o[r] = rv;
        end else begin : g_ns
            logic unused_live;
            assign unused_live  = ^live_i[r];
            assign restore_o[r] = '0;
        end
    end

    assign depth_o      = depth_q;
    assign full_o       = full;
    assign empty_o      = empty;
    assign err_o        = err_q;
    assign restore_en_o = pop_ok;

endmodule

// File: rtl/regfile_ctx.sv
// Register file with async reads, one write port, debug path and context stack.
// Ports: clk/rst, pipeline write (we, wr_*), rd_addr/rd_data, ctx_* stack control
// and status, dbg_* debug write, dbg_regs flopped live view.
module regfile_ctx
    import regfile_pkg::*;
#(
    parameter int          NUM_REGS     = 32,
    parameter int          DATA_W       = 32,
    parameter int          NUM_RD_PORTS = 2,
    parameter logic [31:0] SAVE_MASK    = 32'h0000_0006,
    parameter int          CTX_DEPTH    = 4,
    localparam int         LVL_W        = $clog2(CTX_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [4:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [LVL_W-1:0]  wr_ctx,
    input  logic [4:0]        rd_addr [NUM_RD_PORTS],
    output logic [DATA_W-1:0] rd_data [NUM_RD_PORTS],
    input  logic              ctx_push,
    input  logic              ctx_pop,
    output logic [LVL_W-1:0]  ctx_depth,
    output logic              ctx_full,
    output logic              ctx_empty,
    output logic              ctx_err,
    input  logic              dbg_we,
    input  logic [4:0]        dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic [DATA_W-1:0] dbg_regs [NUM_REGS]
);

    logic [DATA_W-1:0] live_q  [NUM_REGS];
    logic [DATA_W-1:0] live_d  [NUM_REGS];
    logic [DATA_W-1:0] restore [NUM_REGS];
    logic              dbg_hit, pipe_we, live_we, restore_en;

    assign dbg_hit = dbg_we && dbg_addr != REG_ZERO;
    assign pipe_we = we && wr_addr != REG_ZERO && !dbg_hit;

    regfile_ctx_stack #(
        .NUM_REGS  (NUM_REGS),
        .DATA_W    (DATA_W),
        .SAVE_MASK (SAVE_MASK),
        .CTX_DEPTH (CTX_DEPTH),
        .LVL_W     (LVL_W)
    ) u_stack (
        .clk          (clk),
        .rst          (rst),
        .push_i       (ctx_push),
        .pop_i        (ctx_pop),
        .we_i         (pipe_we),
        .wr_addr_i    (wr_addr),
        .wr_data_i    (wr_data),
        .wr_ctx_i     (wr_ctx),
        .live_i       (live_q),
        .depth_o      (ctx_depth),
        .full_o       (ctx_full),
        .empty_o      (ctx_empty),
        .err_o        (ctx_err),
        .live_we_o    (live_we),
        .restore_en_o (restore_en),
        .restore_o    (restore)
    );

    // Restore beats a live write to a saved register in a pop cycle.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            live_d[r] = live_q[r];
            if (r == 0) begin
                live_d[r] = '0;
            end else if (dbg_hit && dbg_addr == 5'(r)) begin
                live_d[r] = dbg_wdata;
            end else if (restore_en && SAVE_MASK[r]) begin
                live_d[r] = restore[r];
            end else if (live_we && wr_addr == 5'(r)) begin
                live_d[r] = wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int r = 0; r < NUM_REGS; r++) begin
            if (rst) begin
                live_q[r] <= '0;
            end else begin
                live_q[r] <= live_d[r];
            end
        end
    end

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
        always_comb begin
            if (rst) begin
                rd_data[p] = '0;
            end else if (rd_addr[p] == REG_ZERO) begin
                rd_data[p] = '0;
            end else if (live_we && wr_addr == rd_addr[p]) begin
                rd_data[p] = wr_data;
            end else begin
                rd_data[p] = live_q[rd_addr[p]];
            end
        end
    end

    for (genvar r = 0; r < NUM_REGS; r++) begin : g_dbg
        assign dbg_regs[r] = live_q[r];
    end

endmodule

// File: tb/tb_regfile_ctx.sv
// Self-checking bench for regfile_ctx: directed scenarios plus randomized
// traffic checked against an array-based model of the live file and stack.
module tb_regfile_ctx;

    localparam int          DEPTH = 4;
    localparam logic [31:0] MASK  = 32'h0000_0006;

    logic        clk = 1'b0;
    logic        rst, we, ctx_push, ctx_pop, dbg_we;
    logic [4:0]  wr_addr, dbg_addr;
    logic [31:0] wr_data, dbg_wdata;
    logic [2:0]  wr_ctx;
    logic [4:0]  rd_addr [2];
    logic [31:0] rd_data [2];
    logic [2:0]  ctx_depth;
    logic        ctx_full, ctx_empty, ctx_err;
    logic [31:0] dbg_regs [32];

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [31:0] m_live [32];
    logic [31:0] m_stk  [DEPTH][32];
    int          m_dep;
    logic        m_err;

    regfile_ctx dut (
        .clk       (clk),
        .rst       (rst),
        .we        (we),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ctx    (wr_ctx),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .ctx_push  (ctx_push),
        .ctx_pop   (ctx_pop),
        .ctx_depth (ctx_depth),
        .ctx_full  (ctx_full),
        .ctx_empty (ctx_empty),
        .ctx_err   (ctx_err),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_regs  (dbg_regs)
    );

    always #5 clk = ~clk;

    task automatic idle();
        rst = 0; we = 0; wr_addr = 0; wr_data = 0; wr_ctx = 0;
        ctx_push = 0; ctx_pop = 0;
        dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
        rd_addr[0] = 0; rd_addr[1] = 0;
    endtask

    function automatic bit goes_live();
        if (!we || wr_addr == 0 || (dbg_we && dbg_addr != 0)) return 0;
        if (int'(wr_ctx) == m_dep) return 1;
        if (int'(wr_ctx) < m_dep && !MASK[wr_addr]) return 1;
        return 0;
    endfunction

    function automatic logic [31:0] exp_rd(logic [4:0] a);
        if (rst || a == 0) return 32'h0;
        if (goes_live() && wr_addr == a) return wr_data;
        return m_live[a];
    endfunction

    // Advance one clock, applying the behavioural rules to the model.
    task automatic tick();
        logic [31:0] nl [32];
        logic [31:0] ns [DEPTH][32];
        int nd, c;
        logic ne;
        bit dbg, pw;
        nl = m_live; ns = m_stk; nd = m_dep; ne = 0;
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                nl[i] = 0;
                for (int s = 0; s < DEPTH; s++) ns[s][i] = 0;
            end
            nd = 0;
        end else begin
            dbg = dbg_we && dbg_addr != 0;
            pw = we && wr_addr != 0 && !dbg;
            c = int'(wr_ctx);
            if (pw) begin
                if (c > m_dep) ne = 1;
                else if (c < m_dep && MASK[wr_addr]) ns[c][wr_addr] = wr_data;
                else nl[wr_addr] = wr_data;
            end
            if (ctx_push && ctx_pop) begin
                ne = 1;
            end else if (ctx_push) begin
                if (m_dep == DEPTH) ne = 1;
                else begin
                    for (int i = 1; i < 32; i++)
                        if (MASK[i]) ns[m_dep][i] = nl[i];
                    nd = m_dep + 1;
                end
            end else if (ctx_pop) begin
                if (m_dep == 0) ne = 1;
                else begin
                    for (int i = 1; i < 32; i++)
                        if (MASK[i]) nl[i] = ns[m_dep-1][i];
                    nd = m_dep - 1;
                end
            end
            if (dbg) nl[dbg_addr] = dbg_wdata;
        end
        @(posedge clk);
        #1;
        m_live = nl; m_stk = ns; m_dep = nd; m_err = ne;
    endtask

    task automatic test_reset();
        idle();
        rst = 1; rd_addr[0] = 1;
        #1;
        total_cnt++;
        if (rd_data[0] !== 32'h0) $display("FAIL rst_read got %h want 0", rd_data[0]);
        else pass_cnt++;
        tick();
        idle();
        #1;
        total_cnt++;
        if (ctx_depth !== 3'd0 || ctx_empty !== 1'b1 || ctx_full !== 1'b0 || ctx_err !== 1'b0)
            $display("FAIL reset_status got d=%0d e=%b f=%b err=%b want 0 1 0 0",
                     ctx_depth, ctx_empty, ctx_full, ctx_err);
        else pass_cnt++;
        total_cnt++;
        if (dbg_regs[1] !== 32'h0) $display("FAIL reset_x1 got %h want 0", dbg_regs[1]);
        else pass_cnt++;
    endtask

    task automatic test_bypass();
        idle();
        we = 1; wr_addr = 5; wr_data = 32'hDEAD_BEEF; wr_ctx = 0;
        rd_addr[0] = 5; rd_addr[1] = 5;
        #1;
        for (int p = 0; p < 2; p++) begin
            total_cnt++;
            if (rd_data[p] !== 32'hDEAD_BEEF)
                $display("FAIL bypass_port%0d got %h want deadbeef", p, rd_data[p]);
            else pass_cnt++;
        end
        tick();
        idle();
        we = 1; wr_addr = 0; wr_data = 32'hFFFF_FFFF;
        #1;
        total_cnt++;
        if (rd_data[0] !== 32'h0) $display("FAIL x0_read got %h want 0", rd_data[0]);
        else pass_cnt++;
        tick();
        idle();
        total_cnt++;
        if (dbg_regs[5] !== 32'hDEAD_BEEF || dbg_regs[0] !== 32'h0)
            $display("FAIL x5_x0_stored got %h %h want deadbeef 0", dbg_regs[5], dbg_regs[0]);
        else pass_cnt++;
    endtask

    task automatic test_push_pop();
        idle(); we = 1; wr_addr = 1; wr_data = 32'h11; wr_ctx = 0;
        tick();
        idle(); ctx_push = 1;
        tick();
        idle();
        total_cnt++;
        if (ctx_depth !== 3'd1) $display("FAIL push_depth got %0d want 1", ctx_depth);
        else pass_cnt++;
        we = 1; wr_addr = 1; wr_data = 32'h22; wr_ctx = 1;
        tick();
        idle();
        total_cnt++;
        if (dbg_regs[1] !== 32'h22) $display("FAIL handler_x1 got %h want 22", dbg_regs[1]);
        else pass_cnt++;
        ctx_pop = 1;
        tick();
        idle();
        total_cnt++;
        if (dbg_regs[1] !== 32'h11 || ctx_depth !== 3'd0)
            $display("FAIL pop_restore got x1=%h d=%0d want 11 0", dbg_regs[1], ctx_depth);
        else pass_cnt++;
    endtask

    task automatic test_shadow_write();
        idle(); we = 1; wr_addr = 2; wr_data = 32'h33; wr_ctx = 0;
        tick();
        idle(); ctx_push = 1;
        tick();
        idle();
        we = 1; wr_addr = 2; wr_data = 32'h77; wr_ctx = 0; rd_addr[0] = 2;
        #1;
        total_cnt++;
        if (rd_data[0] !== 32'h33) $display("FAIL shadow_nobypass got %h want 33", rd_data[0]);
        else pass_cnt++;
        tick();
        idle();
        total_cnt++;
        if (dbg_regs[2] !== 32'h33) $display("FAIL shadow_live got %h want 33", dbg_regs[2]);
        else pass_cnt++;
        ctx_pop = 1;
        tick();
        idle();
        total_cnt++;
        if (dbg_regs[2] !== 32'h77) $display("FAIL shadow_pop got %h want 77", dbg_regs[2]);
        else pass_cnt++;
    endtask

    task automatic test_stack_limits();
        idle(); rst = 1;
        tick();
        for (int i = 0; i <= DEPTH; i++) begin
            idle(); ctx_push = 1;
            tick();
            idle();
            total_cnt++;
            if (ctx_err !== (i == DEPTH))
                $display("FAIL push%0d_err got %b want %b", i, ctx_err, i == DEPTH);
            else pass_cnt++;
        end
        total_cnt++;
        if (ctx_depth !== 3'd4 || ctx_full !== 1'b1)
            $display("FAIL full_state got d=%0d f=%b want 4 1", ctx_depth, ctx_full);
        else pass_cnt++;
        for (int i = 0; i < DEPTH; i++) begin
            idle(); ctx_pop = 1;
            tick();
        end
        idle(); ctx_pop = 1;
        tick();
        idle();
        total_cnt++;
        if (ctx_err !== 1'b1 || ctx_depth !== 3'd0 || ctx_empty !== 1'b1)
            $display("FAIL pop_empty got err=%b d=%0d want 1 0", ctx_err, ctx_depth);
        else pass_cnt++;
        ctx_push = 1;
        tick();
        idle(); ctx_push = 1; ctx_pop = 1;
        tick();
        idle();
        total_cnt++;
        if (ctx_err !== 1'b1 || ctx_depth !== 3'd1)
            $display("FAIL push_pop_err got err=%b d=%0d want 1 1", ctx_err, ctx_depth);
        else pass_cnt++;
    endtask

    task automatic test_pop_write();
        idle();
        ctx_pop = 1; we = 1; wr_addr = 1; wr_data = 32'h5A; wr_ctx = 0;
        tick();
        idle();
        total_cnt++;
        if (dbg_regs[1] !== 32'h5A || ctx_depth !== 3'd0)
            $display("FAIL pop_write got x1=%h d=%0d want 5a 0", dbg_regs[1], ctx_depth);
        else pass_cnt++;
    endtask

    task automatic test_debug();
        idle();
        dbg_we = 1; dbg_addr = 3; dbg_wdata = 32'hCAFE;
        we = 1; wr_addr = 3; wr_data = 32'h1; wr_ctx = 0; rd_addr[0] = 3;
        #1;
        total_cnt++;
        if (rd_data[0] !== 32'h0) $display("FAIL dbg_nobypass got %h want 0", rd_data[0]);
        else pass_cnt++;
        tick();
        idle();
        total_cnt++;
        if (dbg_regs[3] !== 32'hCAFE) $display("FAIL dbg_write got %h want cafe", dbg_regs[3]);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int bad;
        idle(); we = 1; wr_addr = 7; wr_data = 32'hABC; wr_ctx = 0;
        tick();
        idle(); ctx_push = 1;
        tick();
        idle(); ctx_push = 1;
        tick();
        idle();
        total_cnt++;
        if (ctx_depth !== 3'd2) $display("FAIL mid_depth got %0d want 2", ctx_depth);
        else pass_cnt++;
        rst = 1; ctx_push = 1; we = 1; wr_addr = 4; wr_data = 32'h99; wr_ctx = 2;
        tick();
        idle();
        bad = 0;
        for (int i = 0; i < 32; i++) if (dbg_regs[i] !== 32'h0) bad++;
        total_cnt++;
        if (bad != 0 || ctx_depth !== 3'd0 || ctx_empty !== 1'b1)
            $display("FAIL mid_reset got nonzero=%0d d=%0d want 0 0", bad, ctx_depth);
        else pass_cnt++;
    endtask

    task automatic test_random();
        int r, bad;
        for (int n = 0; n < 400; n++) begin
            idle();
            rst = ($urandom % 100) == 0;
            we = ($urandom % 4) != 0;
            wr_addr = 5'($urandom % 8);
            wr_data = $urandom;
            wr_ctx = 3'($urandom_range(0, m_dep + 1));
            r = $urandom % 10;
            ctx_push = (r < 2) || (r == 4);
            ctx_pop = (r == 2) || (r == 3) || (r == 4);
            if (!ctx_push && !ctx_pop && ($urandom % 8) == 0) begin
                dbg_we = 1;
                dbg_addr = 5'($urandom % 8);
                dbg_wdata = $urandom;
            end
            rd_addr[0] = 5'($urandom % 8);
            rd_addr[1] = 5'($urandom % 8);
            #1;
            for (int p = 0; p < 2; p++) begin
                total_cnt++;
                if (rd_data[p] !== exp_rd(rd_addr[p]))
                    $display("FAIL rnd%0d_rd%0d got %h want %h",
                             n, p, rd_data[p], exp_rd(rd_addr[p]));
                else pass_cnt++;
            end
            tick();
            bad = 0;
            for (int i = 0; i < 32; i++) if (dbg_regs[i] !== m_live[i]) bad++;
            total_cnt++;
            if (bad != 0 || ctx_depth !== 3'(m_dep) || ctx_err !== m_err ||
                ctx_full !== (m_dep == DEPTH) || ctx_empty !== (m_dep == 0))
                $display("FAIL rnd%0d_state got regdiff=%0d d=%0d err=%b want 0 %0d %b",
                         n, bad, ctx_depth, ctx_err, m_dep, m_err);
            else pass_cnt++;
        end
    endtask

    initial begin
        for (int i = 0; i < 32; i++) begin
            m_live[i] = 0;
            for (int s = 0; s < DEPTH; s++) m_stk[s][i] = 0;
        end
        m_dep = 0;
        m_err = 0;
        idle();
        @(negedge clk);
        test_reset();
        test_bypass();
        test_push_pop();
        test_shadow_write();
        test_stack_limits();
        test_pop_write();
        test_debug();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/regfile_ctx.md
# regfile_ctx

Parametrised integer register file with N asynchronous read ports, one synchronous write port, and a hardware context stack that saves and restores a configurable register subset across nested interrupts. Each write carries a context tag, so in-flight writes from an interrupted context update that context's saved copy instead of corrupting the handler's live registers. It sits in decode/writeback of the CPU, and the interrupt controller drives `ctx_push` and `ctx_pop`.

## Interface
- `NUM_REGS`, 32: architectural registers; register 0 is hardwired to zero.
- `DATA_W`, 32: register width.
- `NUM_RD_PORTS`, 2: asynchronous read ports.
- `SAVE_MASK`, `32'h0000_0006`: bit i set means register i is saved and restored. Bit 0 is ignored.
- `CTX_DEPTH`, 4: maximum nesting depth, at least 1. `LVL_W = $clog2(CTX_DEPTH+1)`.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous and active-high.
- `we` in 1: pipeline write enable.
- `wr_addr` in 5: pipeline write register.
- `wr_data` in DATA_W: pipeline write data.
- `wr_ctx` in LVL_W: nesting level the writing instruction was issued at.
- `rd_addr[NUM_RD_PORTS]` in 5 each: read addresses.
- `rd_data[NUM_RD_PORTS]` out DATA_W each: read data.
- `ctx_push` in 1: interrupt entry, one-cycle pulse.
- `ctx_pop` in 1: interrupt return, one-cycle pulse.
- `ctx_depth` out LVL_W: current nesting level.
- `ctx_full` out 1: `ctx_depth == CTX_DEPTH`.
- `ctx_empty` out 1: `ctx_depth == 0`.
- `ctx_err` out 1: one-cycle pulse on an illegal stack operation or a dropped write.
- `dbg_we` in 1: debug write enable.
- `dbg_addr` in 5: debug write register.
- `dbg_wdata` in DATA_W: debug write data.
- `dbg_regs[NUM_REGS]` out DATA_W each: live register file, flopped values.

## Operation
- Write routing is decided on pre-edge `ctx_depth` (D), for `we` with `wr_addr != 0`:
  - `wr_ctx == D`: the write goes to the live file.
  - `wr_ctx < D` and `SAVE_MASK[wr_addr]`: the write goes to stack slot `wr_ctx` only.
  - `wr_ctx < D` and the register is not masked: the write goes to the live file.
  - `wr_ctx > D`: the write is dropped and `ctx_err` pulses.
- `dbg_we` with `dbg_addr != 0` writes the live file and suppresses any pipeline write in the same cycle. Debug writes happen only while the core is halted.
- Push, when not full: slot D takes the masked live registers, and D increments. If the same cycle also has a live write to a masked register, the snapshot captures `wr_data`, and the live file is written too.
- Pop, when not empty: masked live registers are restored from slot D-1, and D decrements. If the same cycle has a write with `wr_ctx == D-1` to a masked register, that register takes `wr_data` instead of the slot value.
- A live write in a pop cycle to a masked register is discarded; the restore wins.
- Illegal stack operations leave state unchanged and pulse `ctx_err`:
  - push while full;
  - pop while empty;
  - push and pop asserted together.
- Reads are combinational with priority, highest first:
  1. `rst` forces 0.
  2. Address 0 reads 0.
  3. A same-cycle pipeline write that targets the live file at this address is bypassed (`wr_data`).
  4. Otherwise the flopped live value.
  - Writes routed to the stack, dropped, or suppressed by `dbg_we` are never bypassed.

## Timing
- Reset, synchronous: all live registers, all stack slots and `ctx_depth` clear to 0. `ctx_empty` = 1, `ctx_full` = 0, `ctx_err` = 0. Reset overrides any push, pop or write in the same cycle.
- Write, push and pop take effect at the next rising edge. Read latency is 0 cycles.
- `ctx_err` is registered and asserts the cycle after the offending edge.
- `ctx_depth`, `ctx_full` and `ctx_empty` are registered. `dbg_regs` reflects flopped state only, with no bypass.
- A pop followed by a push on the next cycle is legal and requires no bubble.

## Structure
- `regfile_pkg` holds:
  - the `ctx_lvl_t` typedef (LVL_W bits);
  - the `reg_addr_t` typedef (5 bits);
  - `REG_ZERO`.
- Sub-module `regfile_ctx_stack` holds:
  - the `CTX_DEPTH` × popcount(`SAVE_MASK`) slot array;
  - the depth counter;
  - full, empty and error logic;
  - shadow-write routing.
- The top level holds the live array, the read muxes, bypass and the debug path.

## Test plan
- Reset, then write x5 = `32'hDEAD_BEEF` and read x5 on both ports in the same cycle: bypassed value is returned. x0 reads 0 after a write of `32'hFFFF_FFFF`.
- x1 = `32'h11`, push, write x1 = `32'h22` with `wr_ctx` = 1, pop: x1 = `32'h11` and depth returns to 0.
- Depth 1, write x2 = `32'h77` with `wr_ctx` = 0: live x2 is unchanged and x2 is not bypassed. After pop, x2 = `32'h77`.
- Push CTX_DEPTH+1 times: `ctx_full` is set, the last push pulses `ctx_err`, and depth stays at CTX_DEPTH. Pop from empty pulses `ctx_err`. Push with pop pulses `ctx_err` and depth is unchanged.
- Pop cycle with a write x1 = `32'h5A` and `wr_ctx` = D-1: x1 = `32'h5A` after the edge.
- `dbg_we` x3 = `32'hCAFE` together with pipeline write x3 = `32'h1`: x3 = `32'hCAFE`. Assert `rst` mid-nesting at depth 2: all state is 0 next cycle.
